// File: rtl/bintobcd_pkg.sv
// Shared constants and state type for the binary-to-BCD display converter.
package bintobcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CONV_W = 24;
  localparam int NDIG   = 7;
  localparam int ITER   = 24;
  localparam int CNT_W  = 5;

  localparam logic [31:0] OVF_LIMIT = 32'd10_000_000;

  // Bit i lights the point to the right of displayed digit i.
  localparam logic [3:0] DP_NONE = 4'b0000;
  localparam logic [3:0] DP_D0   = 4'b0001;
  localparam logic [3:0] DP_D1   = 4'b0010;
  localparam logic [3:0] DP_D2   = 4'b0100;
  localparam logic [3:0] DP_D3   = 4'b1000;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    if (din_i >= 4'd5) begin
      dout_o = din_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter with auto-ranging 4-digit window and decimal point.
module bin_to_bcd
  import bintobcd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_bin,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_overflow,
  output logic [3:0]  o_bcd3,
  output logic [3:0]  o_bcd2,
  output logic [3:0]  o_bcd1,
  output logic [3:0]  o_bcd0,
  output logic [3:0]  o_dp
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CONV_W-1:0]    shift_q, shift_d;
  logic [NDIG*4-1:0]    bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 ovfout_q, ovfout_d;
  logic [15:0]          disp_q, disp_d;
  logic [3:0]           dp_q, dp_d;

  logic [NDIG*4-1:0]    adj;
  logic [15:0]          win;
  logic [3:0]           win_dp;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din_i  (bcd_q[g*4 +: 4]),
      .dout_o (adj[g*4 +: 4])
    );
  end

  // Show the four most significant digits starting at the first non-zero one (truncating).
  always_comb begin
    win    = bcd_q[15:0];
    win_dp = DP_D3;
    if (bcd_q[27:24] != 4'd0) begin
      win    = bcd_q[27:12];
      win_dp = DP_D0;
    end else if (bcd_q[23:20] != 4'd0) begin
      win    = bcd_q[23:8];
      win_dp = DP_D1;
    end else if (bcd_q[19:16] != 4'd0) begin
      win    = bcd_q[19:4];
      win_dp = DP_D2;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    ovfout_d = ovfout_q;
    disp_d   = disp_q;
    dp_d     = dp_q;
    unique case (state_q)
      IDLE: begin
        // The done cycle counts as not-ready, so starts are refused until it ends.
        if (i_start && !done_q) begin
          if (i_bin >= OVF_LIMIT) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            ovf_d   = 1'b0;
            shift_d = i_bin[CONV_W-1:0];
            bcd_d   = '0;
            cnt_d   = CNT_W'(ITER);
            state_d = OP;
          end
        end
      end
      OP: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (ovf_q) begin
          ovfout_d = 1'b1;
          disp_d   = 16'hFFFF;
          dp_d     = DP_NONE;
        end else begin
          ovfout_d = 1'b0;
          disp_d   = win;
          dp_d     = win_dp;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ovfout_q <= 1'b0;
      disp_q   <= '0;
      dp_q     <= DP_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ovfout_q <= ovfout_d;
      disp_q   <= disp_d;
      dp_q     <= dp_d;
    end
  end

  assign o_ready    = (state_q == IDLE) && !done_q;
  assign o_done     = done_q;
  assign o_overflow = ovfout_q;
  assign o_bcd3     = disp_q[15:12];
  assign o_bcd2     = disp_q[11:8];
  assign o_bcd1     = disp_q[7:4];
  assign o_bcd0     = disp_q[3:0];
  assign o_dp       = dp_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed, boundary, overflow, random and reset scenarios.
module tb_bin_to_bcd;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_bin;
  logic        o_ready;
  logic        o_done;
  logic        o_overflow;
  logic [3:0]  o_bcd3, o_bcd2, o_bcd1, o_bcd0;
  logic [3:0]  o_dp;

  int testsRun    = 0;
  int testsFailed = 0;

  bin_to_bcd dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_ready    (o_ready),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_bcd3     (o_bcd3),
    .o_bcd2     (o_bcd2),
    .o_bcd1     (o_bcd1),
    .o_bcd0     (o_bcd0),
    .o_dp       (o_dp)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Expected {overflow, d3, d2, d1, d0, dp} from the decimal value itself.
  function automatic logic [20:0] model_result(input logic [31:0] v);
    int unsigned x;
    int unsigned shown;
    logic [3:0]  dp;
    x = v;
    if (x >= 32'd10_000_000) return {1'b1, 16'hFFFF, 4'b0000};
    if (x >= 1_000_000) begin
      shown = x / 1000; dp = 4'b0001;
    end else if (x >= 100_000) begin
      shown = x / 100;  dp = 4'b0010;
    end else if (x >= 10_000) begin
      shown = x / 10;   dp = 4'b0100;
    end else begin
      shown = x;        dp = 4'b1000;
    end
    return {1'b0, 4'(shown / 1000), 4'((shown / 100) % 10), 4'((shown / 10) % 10),
            4'(shown % 10), dp};
  endfunction

  function automatic logic [20:0] observed();
    return {o_overflow, o_bcd3, o_bcd2, o_bcd1, o_bcd0, o_dp};
  endfunction

  // Starts one conversion and returns the edge count from the accepting edge to o_done.
  task automatic run_conv(input logic [31:0] v, input bit disturb,
                          output int lat, output logic rdyAtDone);
    int guard;
    guard = 0;
    while (!o_ready && guard < 50) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_start = 1'b1;
    i_bin   = v;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = 0;
    rdyAtDone = 1'bx;
    while (lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_done) begin
        rdyAtDone = o_ready;
        i_start = 1'b0;
        break;
      end
      if (disturb) begin
        if (lat >= 3 && lat <= 6) begin
          i_start = 1'b1;
          i_bin   = $urandom;
        end else begin
          i_start = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    testsRun++;
    if ({o_ready, o_done, observed()} !== {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %h expected %h",
               {o_ready, o_done, observed()}, {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000});
    end
  endtask

  task automatic test_directed();
    logic [31:0] vals [12] = '{32'd9_999_999, 32'd0, 32'd6767, 32'd7_676_767,
                               32'd123_456, 32'd45_678, 32'd9_999, 32'd10_000,
                               32'd99_999, 32'd100_000, 32'd999_999, 32'd1_000_000};
    int lat;
    logic rdy;
    for (int i = 0; i < 12; i++) begin
      run_conv(vals[i], 1'b0, lat, rdy);
      testsRun++;
      if (lat !== 25) begin
        testsFailed++;
        $display("[TB] FAIL directed_latency(%0d): got %0d expected 25", vals[i], lat);
      end
      testsRun++;
      if (observed() !== model_result(vals[i])) begin
        testsFailed++;
        $display("[TB] FAIL directed_result(%0d): got %h expected %h",
                 vals[i], observed(), model_result(vals[i]));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [4] = '{32'd67_676_767, 32'd10_000_000, 32'hFFFF_FFFF, 32'd1234};
    int lat;
    logic rdy;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], 1'b0, lat, rdy);
      testsRun++;
      if (lat !== ((i < 3) ? 1 : 25)) begin
        testsFailed++;
        $display("[TB] FAIL overflow_latency(%0d): got %0d expected %0d",
                 vals[i], lat, (i < 3) ? 1 : 25);
      end
      testsRun++;
      if (observed() !== model_result(vals[i])) begin
        testsFailed++;
        $display("[TB] FAIL overflow_result(%0d): got %h expected %h",
                 vals[i], observed(), model_result(vals[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int lat;
    logic rdy;
    for (int i = 0; i < 30; i++) begin
      v = (i % 5 == 4) ? $urandom : $urandom_range(0, 9_999_999);
      run_conv(v, 1'b0, lat, rdy);
      testsRun++;
      if (observed() !== model_result(v) || lat !== ((v >= 32'd10_000_000) ? 1 : 25)) begin
        testsFailed++;
        $display("[TB] FAIL random(%0d): got %h lat %0d expected %h",
                 v, observed(), lat, model_result(v));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] v;
    int lat;
    int extra;
    logic rdy;
    v = $urandom_range(1_000_000, 9_999_999);
    run_conv(v, 1'b1, lat, rdy);
    testsRun++;
    if (observed() !== model_result(v) || lat !== 25) begin
      testsFailed++;
      $display("[TB] FAIL ignore_start(%0d): got %h lat %0d expected %h",
               v, observed(), lat, model_result(v));
    end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      if (o_done) extra++;
    end
    testsRun++;
    if (extra !== 0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_start_extra_done: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int dones;
    logic rdy;
    run_conv(32'd7_676_767, 1'b0, lat, rdy);
    i_start = 1'b1;
    i_bin   = 32'd5_555_555;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    testsRun++;
    if ({o_ready, o_done, observed()} !== {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_op: got %h expected %h",
               {o_ready, o_done, observed()}, {1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    testsRun++;
    if (dones !== 0 || observed() !== 21'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_done: got dones %0d out %h expected 0 and 0", dones, observed());
    end
    run_conv(32'd6767, 1'b0, lat, rdy);
    testsRun++;
    if (observed() !== model_result(32'd6767) || lat !== 25) begin
      testsFailed++;
      $display("[TB] FAIL after_reset(6767): got %h lat %0d expected %h",
               observed(), lat, model_result(32'd6767));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic rdy;
    run_conv(32'd45_678, 1'b0, lat, rdy);
    testsRun++;
    if (rdy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ready_during_done: got %b expected 0", rdy);
    end
    @(posedge i_clk); #1;
    testsRun++;
    if ({o_ready, o_done} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL ready_after_done: got %b expected 10", {o_ready, o_done});
    end
    run_conv(32'd123_456, 1'b0, lat, rdy);
    testsRun++;
    if (observed() !== model_result(32'd123_456) || lat !== 25) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back(123456): got %h lat %0d expected %h",
               observed(), lat, model_result(32'd123_456));
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    #12;
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    test_directed();
    test_overflow();
    test_random();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
